// File: rtl/uv_double_counter.sv
// uv_double_counter: row-major 2-D index scanner over a BLOCK_SIZE x BLOCK_SIZE
// grid. v is the inner (column) index and u the outer (row) index. The scan
// saturates on the final position and reports it on done.
//
// Ports:
//   clk     - single clock, all state updates on its rising edge
//   rst     - asynchronous active-high reset, forces (u,v) = (0,0)
//   restart - synchronous return to (0,0); has priority over go
//   go      - advance the scan by one position this cycle
//   u       - outer (row) index, registered
//   v       - inner (column) index, registered
//   done    - high while (u,v) sits on (N-1,N-1); pure decode of u and v
//
// Contains uv_en_reg, the reusable enabled register that holds u and v.

// uv_en_reg: WIDTH-bit register with clock enable and an asynchronous reset
// that loads a caller-supplied reset value.
//
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset, Q <= rst_val
//   en      - load enable, Q <= D on the rising edge when high
//   rst_val - value loaded while rst is asserted
//   D       - data in
//   Q       - data out
module uv_en_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= rst_val;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

module uv_double_counter #(
    parameter int unsigned BLOCK_SIZE = 8,  // power of two, 2..256
    parameter int unsigned IDX_W      = 3   // log2(BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             go,
    output logic [IDX_W-1:0] u,
    output logic [IDX_W-1:0] v,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_SIZE - 1);

    logic [IDX_W-1:0] u_next;
    logic [IDX_W-1:0] v_next;
    logic             u_en;
    logic             v_en;
    logic             u_last;
    logic             v_last;

    assign u_last = (u == LAST);
    assign v_last = (v == LAST);

    // Next-position logic. Each index register is only enabled when its value
    // actually changes; at the final position neither is enabled, which gives
    // saturation rather than wrap-around.
    always_comb begin
        u_next = u;
        v_next = v;
        u_en   = 1'b0;
        v_en   = 1'b0;
        if (restart) begin
            u_next = '0;
            v_next = '0;
            u_en   = 1'b1;
            v_en   = 1'b1;
        end else if (go) begin
            if (!v_last) begin
                v_next = v + 1'b1;
                v_en   = 1'b1;
            end else if (!u_last) begin
                v_next = '0;
                u_next = u + 1'b1;
                v_en   = 1'b1;
                u_en   = 1'b1;
            end
        end
    end

    uv_en_reg #(
        .WIDTH (IDX_W)
    ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (u_en),
        .rst_val ('0),
        .D       (u_next),
        .Q       (u)
    );

    uv_en_reg #(
        .WIDTH (IDX_W)
    ) v_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (v_en),
        .rst_val ('0),
        .D       (v_next),
        .Q       (v)
    );

    assign done = u_last && v_last;

endmodule

// File: tb/tb_uv_double_counter.sv
// Directed testbench for uv_double_counter with N = 8.
module tb_uv_double_counter;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk;
    logic         rst;
    logic         restart;
    logic         go;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic         done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    uv_double_counter #(
        .BLOCK_SIZE (N),
        .IDX_W      (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .go      (go),
        .u       (u),
        .v       (v),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int eu, input int ev, input int edone);
        check({tag, ".u"}, 32'(u), 32'(eu));
        check({tag, ".v"}, 32'(v), 32'(ev));
        check({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic advance(input int n);
        go = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        rst     = 1'b0;
        restart = 1'b0;
        go      = 1'b0;
        #2 rst  = 1'b1;
        #1 check_pos("reset", 0, 0, 0);

        // Full scan: after k edges the position is (k/8, k%8); done only at 63.
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            step();
            check_pos($sformatf("scan1 k=%0d", k), k / 8, k % 8, (k == 63) ? 1 : 0);
        end

        // Saturation at the final position.
        for (int k = 0; k < 5; k++) begin
            step();
            check_pos($sformatf("sat k=%0d", k), 7, 7, 1);
        end
        go = 1'b0;
        step();
        check_pos("final_idle", 7, 7, 1);

        // Restart from the final position, then a second full scan.
        restart = 1'b1;
        step();
        check_pos("restart_final", 0, 0, 0);
        restart = 1'b0;
        go      = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            step();
            check_pos($sformatf("scan2 k=%0d", k), k / 8, k % 8, (k == 63) ? 1 : 0);
        end

        // Hold at (3,5) with go low, then resume across a row boundary.
        restart = 1'b1;
        step();
        restart = 1'b0;
        advance(29);
        check_pos("at_3_5", 3, 5, 0);
        go = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_pos($sformatf("hold k=%0d", k), 3, 5, 0);
        end
        go = 1'b1;
        step();
        check_pos("resume_3_6", 3, 6, 0);
        step();
        check_pos("resume_3_7", 3, 7, 0);
        step();
        check_pos("resume_4_0", 4, 0, 0);

        // restart and go together at (2,7): restart wins.
        restart = 1'b1;
        step();
        restart = 1'b0;
        advance(23);
        check_pos("at_2_7", 2, 7, 0);
        restart = 1'b1;
        go      = 1'b1;
        step();
        check_pos("restart_over_go", 0, 0, 0);
        restart = 1'b0;

        // Asynchronous reset mid-cycle at (5,2) with go held high.
        advance(42);
        check_pos("at_5_2", 5, 2, 0);
        #2 rst = 1'b1;
        #1 check_pos("async_rst", 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_pos($sformatf("rst_hold k=%0d", k), 0, 0, 0);
        end
        rst = 1'b0;
        step();
        check_pos("post_rst", 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
